ans_ltf_multi_gen: RTL and testbench
====================================

Name: ans_ltf_multi_gen

Overview:
- Parametrised successor to the single-symbol ANS HT-LTF generator.
- Loads per-subcarrier obfuscation-scaled LTF frequency coefficients into an external streaming IFFT and captures one time-domain symbol into a buffer.
- Emits 1..NSYM_MAX LTF symbols, each with a proper cyclic prefix and a per-symbol P-matrix sign, over a valid/ready stream into the dot11 TX path.

Parameters:
- NFFT, 64, FFT size and buffer depth (power of 2).
- CP_LEN, 16, cyclic-prefix samples per symbol (0 < CP_LEN < NFFT).
- NSYM_MAX, 4, maximum LTF symbols per burst.
- IQ_W, 16, width of each of I and Q (two's complement, I in the upper half).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle burst request
- nsym  in  $clog2(NSYM_MAX+1)  symbols in burst, latched at start
- sym_sign  in  NSYM_MAX  bit k=1 negates symbol k, latched at start
- obf_coeff  in  2*NFFT  2-bit scale code per subcarrier, latched at start
- rom_addr  out  $clog2(NFFT)  frequency ROM address
- rom_data  in  2*IQ_W  ROM word, combinational w.r.t. rom_addr
- ifft_ce  out  1  IFFT clock enable
- ifft_in  out  2*IQ_W  IFFT input sample
- ifft_out  in  2*IQ_W  IFFT output sample
- ifft_sync  in  1  IFFT marks the first output sample
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_iq  out  2*IQ_W  output sample
- out_last  out  1  final sample of burst
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: out_valid=0, out_last=0, out_iq=0, ifft_ce=0, ifft_in=0, rom_addr=0, busy=0, state=IDLE. Buffer contents are don't-care.
- Reset mid-operation: returns to IDLE within one cycle. No partial burst resumes.
- States:
  - IDLE: on start, latch nsym, sym_sign and obf_coeff; set idx=0 and ifft_ce=1; go to LOAD.
    - nsym=0 is treated as 1; nsym>NSYM_MAX is clamped to NSYM_MAX.
    - start while busy is ignored.
  - LOAD: one coefficient per cycle for NFFT cycles; rom_addr=idx; ifft_in=scale(rom_data, code[idx]). After idx=NFFT-1, go to WAIT.
  - WAIT: ifft_in=0, ifft_ce=1. On ifft_sync, write buf[0]=ifft_out and go to BUFFER with idx=1.
  - BUFFER: write buf[idx]=ifft_out each cycle. After idx=NFFT-1, drop ifft_ce and go to EMIT with sym=0, pos=0.
  - EMIT: out_valid=1.
    - Buffer index = pos<CP_LEN ? NFFT-CP_LEN+pos : pos-CP_LEN.
    - out_iq=buf[index], negated when sym_sign[sym]=1.
    - Advance only when out_valid&&out_ready. pos wraps at NFFT+CP_LEN-1 and sym increments.
    - out_last=1 on sym=nsym-1 and pos=NFFT+CP_LEN-1. The accepting handshake on that sample returns to IDLE; out_valid falls on the next cycle.
  - Stall: out_iq and out_last are held stable while out_valid && !out_ready.
- Scale codes: arithmetic shift right on each of I and Q independently, sign-extended, truncated.
  - 00 = x1
  - 01 = /8
  - 10 = /2
  - 11 = /4
- Negation saturates: -(-2^(IQ_W-1)) = 2^(IQ_W-1)-1. Applied per component.
- Latency: start to first out_valid = NFFT (LOAD) + IFFT latency + NFFT (BUFFER) + 1 cycles.
- Burst length is exactly nsym*(NFFT+CP_LEN) accepted samples.

Optional Feature:
- Macro: ANS_LTF_CACHE_EN.
- Defined:
  - Adds input cache_use (1 bit).
  - start with cache_use=1, when the buffer holds a valid symbol and the latched obf_coeff equals the new obf_coeff, goes directly IDLE -> EMIT. LOAD/WAIT/BUFFER are skipped and ifft_ce stays 0.
  - The buffer-valid flag is cleared by reset and set on BUFFER completion.
- Not defined: every start performs the full LOAD/IFFT cycle; there is no cache_use port.

Decomposition:
- Package ans_ltf_pkg:
  - state encoding IDLE/LOAD/WAIT/BUFFER/EMIT
  - scale-code localparams SC_X1=2'b00, SC_D8=2'b01, SC_D2=2'b10, SC_D4=2'b11
  - saturating-negate and arithmetic-shift functions
- Sub-module ans_ltf_sym_buf: NFFT x 2*IQ_W buffer with a synchronous write port and a read port implementing the CP index mapping and sign/saturation. Its output is registered, so EMIT prefetches one sample ahead.

Test Plan:
- ROM word 0x4000_C000 at all addresses, all codes 10, nsym=1, CP_LEN=16, out_ready=1 -> ifft_in=0x2000_E000 for 64 cycles; 80 output samples; out_last only on sample 80; samples 0..15 equal samples 64..79.
- Codes 00/01/10/11 on subcarriers 0..3, ROM word 0x0800_F800 -> ifft_in 0x0800_F800, 0x0100_FF00, 0x0400_FC00, 0x0200_FE00.
- nsym=4, sym_sign=4'b1010, IFFT model producing buf[n]={n,n} -> 320 samples; symbols 1 and 3 are negated; a buf value 0x8000 is emitted as 0x7FFF in the negated symbols.
- out_ready toggling randomly at 50% -> out_iq and out_last stable during stalls; exactly nsym*80 accepted samples; no duplicated or skipped samples.
- Corner cases:
  - start asserted during EMIT -> ignored.
  - reset asserted at sample 37 -> out_valid=0 next cycle, busy=0.
  - nsym=0 -> 80 samples.
  - nsym=7 -> 320 samples.
- With ANS_LTF_CACHE_EN: second start with identical obf_coeff and cache_use=1 -> out_valid asserts 1 cycle after start and ifft_ce stays 0. Changed obf_coeff -> full recompute.

Source files
------------

// File: rtl/ans_ltf_pkg.sv
// Shared state encoding, scale codes and component arithmetic for the ANS LTF generator.
package ans_ltf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      BUFFER,
      EMIT
   } state_t;

   localparam logic [1:0] SC_X1 = 2'b00;
   localparam logic [1:0] SC_D8 = 2'b01;
   localparam logic [1:0] SC_D2 = 2'b10;
   localparam logic [1:0] SC_D4 = 2'b11;

   // Arithmetic right shift selected by a 2-bit scale code (operand pre-sign-extended).
   function automatic logic signed [31:0] asr_code(input logic signed [31:0] x,
                                                   input logic [1:0]         code);
      logic signed [31:0] r;
      case (code)
         SC_D8:   r = x >>> 3;
         SC_D2:   r = x >>> 1;
         SC_D4:   r = x >>> 2;
         default: r = x;
      endcase
      return r;
   endfunction

   // Two's complement negate of a w-bit value; the most negative value maps to the maximum.
   function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                  input int unsigned        w);
      logic signed [31:0] lim;
      lim = 32'sd1 <<< (w - 1);
      if (x == -lim) return lim - 32'sd1;
      return -x;
   endfunction

endpackage

// File: rtl/ans_ltf_sym_buf.sv
// One-symbol sample buffer: synchronous write, registered read with cyclic-prefix
// index mapping and per-component saturating negation.
module ans_ltf_sym_buf
   import ans_ltf_pkg::*;
#(
   parameter int unsigned NFFT   = 64,
   parameter int unsigned CP_LEN = 16,
   parameter int unsigned IQ_W   = 16
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              wr_en,
   input  logic [$clog2(NFFT)-1:0]           wr_addr,
   input  logic [2*IQ_W-1:0]                 wr_data,
   input  logic                              rd_en,
   input  logic [$clog2(NFFT+CP_LEN)-1:0]    rd_pos,
   input  logic                              rd_neg,
   output logic [2*IQ_W-1:0]                 rd_data
);

   localparam int unsigned ADDR_W = $clog2(NFFT);
   localparam int unsigned POS_W  = $clog2(NFFT + CP_LEN);

   logic [2*IQ_W-1:0]     mem [NFFT];
   logic [ADDR_W-1:0]     rd_addr;
   logic [2*IQ_W-1:0]     raw;
   logic signed [IQ_W-1:0] i_s;
   logic signed [IQ_W-1:0] q_s;
   logic [2*IQ_W-1:0]     rd_word;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Prefix samples come from the tail of the symbol; a same-cycle write is forwarded.
   always_comb begin
      if (rd_pos < POS_W'(CP_LEN))
         rd_addr = ADDR_W'(rd_pos + POS_W'(NFFT - CP_LEN));
      else
         rd_addr = ADDR_W'(rd_pos - POS_W'(CP_LEN));
      raw = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      i_s = raw[2*IQ_W-1:IQ_W];
      q_s = raw[IQ_W-1:0];
      if (rd_neg)
         rd_word = {IQ_W'(sat_neg(32'(i_s), IQ_W)), IQ_W'(sat_neg(32'(q_s), IQ_W))};
      else
         rd_word = raw;
   end

   always_ff @(posedge clk) begin
      if (reset)      rd_data <= '0;
      else if (rd_en) rd_data <= rd_word;
   end

endmodule

// File: rtl/ans_ltf_multi_gen.sv
// Multi-symbol ANS HT-LTF generator: feeds scaled coefficients to an external IFFT, buffers
// one symbol and streams nsym copies with cyclic prefix and sign. Option: ANS_LTF_CACHE_EN.
module ans_ltf_multi_gen
   import ans_ltf_pkg::*;
#(
   parameter int unsigned NFFT     = 64,
   parameter int unsigned CP_LEN   = 16,
   parameter int unsigned NSYM_MAX = 4,
   parameter int unsigned IQ_W     = 16
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [$clog2(NSYM_MAX+1)-1:0]     nsym,
   input  logic [NSYM_MAX-1:0]               sym_sign,
   input  logic [2*NFFT-1:0]                 obf_coeff,
`ifdef ANS_LTF_CACHE_EN
   input  logic                              cache_use,
`endif
   output logic [$clog2(NFFT)-1:0]           rom_addr,
   input  logic [2*IQ_W-1:0]                 rom_data,
   output logic                              ifft_ce,
   output logic [2*IQ_W-1:0]                 ifft_in,
   input  logic [2*IQ_W-1:0]                 ifft_out,
   input  logic                              ifft_sync,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [2*IQ_W-1:0]                 out_iq,
   output logic                              out_last,
   output logic                              busy
);

   localparam int unsigned ADDR_W = $clog2(NFFT);
   localparam int unsigned SLEN   = NFFT + CP_LEN;
   localparam int unsigned POS_W  = $clog2(SLEN);
   localparam int unsigned NSYM_W = $clog2(NSYM_MAX + 1);
   localparam int unsigned SYM_W  = (NSYM_MAX > 1) ? $clog2(NSYM_MAX) : 1;

   state_t              state_q, state_n;
   logic [ADDR_W-1:0]   rom_addr_n, idx_q, idx_n;
   logic                ifft_ce_n, out_valid_n, out_last_n, busy_n;
   logic [2*IQ_W-1:0]   ifft_in_n;
   logic [SYM_W-1:0]    sym_q, sym_n, sym_last_q, sym_last_n, nxt_sym;
   logic [POS_W-1:0]    pos_q, pos_n, nxt_pos;
   logic [NSYM_MAX-1:0] sign_q, sign_n;
   logic [2*NFFT-1:0]   coeff_q, coeff_n;
   logic                full_load;

   logic                wr_en, rd_en, rd_neg;
   logic [ADDR_W-1:0]   wr_addr;
   logic [POS_W-1:0]    rd_pos;

`ifdef ANS_LTF_CACHE_EN
   logic                buf_valid_q, buf_valid_n;
`endif

   // Scale each of I and Q independently by the subcarrier's code.
   function automatic logic [2*IQ_W-1:0] scale_word(input logic [2*IQ_W-1:0] w,
                                                    input logic [1:0]        code);
      logic signed [IQ_W-1:0] i_s;
      logic signed [IQ_W-1:0] q_s;
      i_s = w[2*IQ_W-1:IQ_W];
      q_s = w[IQ_W-1:0];
      return {IQ_W'(asr_code(32'(i_s), code)), IQ_W'(asr_code(32'(q_s), code))};
   endfunction

   // Index of the final symbol: 0 requests act as 1, oversize requests clamp to NSYM_MAX.
   function automatic logic [SYM_W-1:0] last_sym(input logic [NSYM_W-1:0] n);
      if (n == '0)                return '0;
      else if (32'(n) > NSYM_MAX) return SYM_W'(NSYM_MAX - 1);
      else                        return SYM_W'(n - 1'b1);
   endfunction

   always_comb begin
      state_n     = state_q;
      rom_addr_n  = rom_addr;
      ifft_ce_n   = ifft_ce;
      ifft_in_n   = ifft_in;
      out_valid_n = out_valid;
      out_last_n  = out_last;
      idx_n       = idx_q;
      sym_n       = sym_q;
      pos_n       = pos_q;
      sym_last_n  = sym_last_q;
      sign_n      = sign_q;
      coeff_n     = coeff_q;
      full_load   = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = idx_q;
      rd_en       = 1'b0;
      rd_pos      = pos_q;
      rd_neg      = sign_q[sym_q];
      nxt_sym     = sym_q;
      nxt_pos     = pos_q + 1'b1;
`ifdef ANS_LTF_CACHE_EN
      buf_valid_n = buf_valid_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               sym_last_n = last_sym(nsym);
               sign_n     = sym_sign;
               coeff_n    = obf_coeff;
`ifdef ANS_LTF_CACHE_EN
               if (cache_use && buf_valid_q && (coeff_q == obf_coeff)) begin
                  state_n     = EMIT;
                  rd_en       = 1'b1;
                  rd_pos      = '0;
                  rd_neg      = sym_sign[0];
                  sym_n       = '0;
                  pos_n       = '0;
                  out_valid_n = 1'b1;
                  out_last_n  = 1'b0;
               end else begin
                  full_load   = 1'b1;
                  buf_valid_n = 1'b0;
               end
`else
               full_load = 1'b1;
`endif
            end
            // rom_addr already sits at 0, so coefficient 0 is presented with ifft_ce.
            if (full_load) begin
               state_n    = LOAD;
               ifft_ce_n  = 1'b1;
               ifft_in_n  = scale_word(rom_data, obf_coeff[1:0]);
               rom_addr_n = ADDR_W'(1);
            end
         end

         LOAD: begin
            if (rom_addr == '0) begin
               state_n   = WAIT;
               ifft_in_n = '0;
            end else begin
               ifft_in_n  = scale_word(rom_data, coeff_q[{rom_addr, 1'b0} +: 2]);
               rom_addr_n = rom_addr + 1'b1;
            end
         end

         WAIT: begin
            if (ifft_sync) begin
               wr_en   = 1'b1;
               wr_addr = '0;
               idx_n   = ADDR_W'(1);
               state_n = BUFFER;
            end
         end

         BUFFER: begin
            wr_en = 1'b1;
            idx_n = idx_q + 1'b1;
            if (idx_q == ADDR_W'(NFFT - 1)) begin
               ifft_ce_n   = 1'b0;
               state_n     = EMIT;
               rd_en       = 1'b1;
               rd_pos      = '0;
               rd_neg      = sign_q[0];
               sym_n       = '0;
               pos_n       = '0;
               out_valid_n = 1'b1;
               out_last_n  = 1'b0;
`ifdef ANS_LTF_CACHE_EN
               buf_valid_n = 1'b1;
`endif
            end
         end

         EMIT: begin
            // The read port is registered, so the next sample is fetched on each accept.
            if (out_ready) begin
               if (out_last) begin
                  state_n     = IDLE;
                  out_valid_n = 1'b0;
                  out_last_n  = 1'b0;
               end else begin
                  if (pos_q == POS_W'(SLEN - 1)) begin
                     nxt_sym = sym_q + 1'b1;
                     nxt_pos = '0;
                  end
                  rd_en      = 1'b1;
                  rd_pos     = nxt_pos;
                  rd_neg     = sign_q[nxt_sym];
                  sym_n      = nxt_sym;
                  pos_n      = nxt_pos;
                  out_last_n = (nxt_sym == sym_last_q) && (nxt_pos == POS_W'(SLEN - 1));
               end
            end
         end

         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rom_addr   <= '0;
         ifft_ce    <= 1'b0;
         ifft_in    <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         idx_q      <= '0;
         sym_q      <= '0;
         pos_q      <= '0;
         sym_last_q <= '0;
         sign_q     <= '0;
         coeff_q    <= '0;
      end else begin
         state_q    <= state_n;
         rom_addr   <= rom_addr_n;
         ifft_ce    <= ifft_ce_n;
         ifft_in    <= ifft_in_n;
         out_valid  <= out_valid_n;
         out_last   <= out_last_n;
         busy       <= busy_n;
         idx_q      <= idx_n;
         sym_q      <= sym_n;
         pos_q      <= pos_n;
         sym_last_q <= sym_last_n;
         sign_q     <= sign_n;
         coeff_q    <= coeff_n;
      end
   end

`ifdef ANS_LTF_CACHE_EN
   always_ff @(posedge clk) begin
      if (reset) buf_valid_q <= 1'b0;
      else       buf_valid_q <= buf_valid_n;
   end
`endif

   ans_ltf_sym_buf #(
      .NFFT   (NFFT),
      .CP_LEN (CP_LEN),
      .IQ_W   (IQ_W)
   ) u_sym_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (ifft_out),
      .rd_en   (rd_en),
      .rd_pos  (rd_pos),
      .rd_neg  (rd_neg),
      .rd_data (out_iq)
   );

endmodule

// File: tb/tb_ans_ltf_multi_gen.sv
// Scoreboard bench for ans_ltf_multi_gen: behavioural IFFT/ROM stand-ins, reference model
// of scaling, cyclic prefix and signing, and a decoupled output monitor.
`timescale 1ns/1ps
module tb_ans_ltf_multi_gen;

   localparam int unsigned NFFT   = 64;
   localparam int unsigned CP_LEN = 16;
   localparam int unsigned SLEN   = NFFT + CP_LEN;
   localparam int unsigned LAT    = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   nsym = 3'd0;
   logic [3:0]   sym_sign = 4'd0;
   logic [127:0] obf_coeff = '0;
`ifdef ANS_LTF_CACHE_EN
   logic         cache_use = 1'b0;
`endif
   logic [5:0]   rom_addr;
   logic [31:0]  rom_data;
   logic         ifft_ce;
   logic [31:0]  ifft_in;
   logic [31:0]  ifft_out = '0;
   logic         ifft_sync = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_iq;
   logic         out_last;
   logic         busy;

   logic [31:0]  rom_mem [NFFT];
   logic [31:0]  td [NFFT];
   logic [32:0]  exp_q [$];
   logic [31:0]  coef_q [$];
   int           tests_run = 0;
   int           tests_failed = 0;
   int           acc_cnt = 0;
   bit           rdy_rand = 1'b0;

   assign rom_data = rom_mem[rom_addr];

   ans_ltf_multi_gen dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .nsym      (nsym),
      .sym_sign  (sym_sign),
      .obf_coeff (obf_coeff),
`ifdef ANS_LTF_CACHE_EN
      .cache_use (cache_use),
`endif
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .ifft_ce   (ifft_ce),
      .ifft_in   (ifft_in),
      .ifft_out  (ifft_out),
      .ifft_sync (ifft_sync),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_iq    (out_iq),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests_run++;
      tests_failed++;
      $display("FAIL %s", name);
   endtask

   // Reference arithmetic: floor division and saturating negate on plain integers.
   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic int fdiv(input int x, input int d);
      if (x >= 0) return x / d;
      return -((-x + d - 1) / d);
   endfunction

   function automatic logic [31:0] ref_scale(input logic [31:0] w, input logic [1:0] c);
      int d;
      d = (c == 2'd0) ? 1 : (c == 2'd1) ? 8 : (c == 2'd2) ? 2 : 4;
      return {16'(fdiv(sx(w[31:16]), d)), 16'(fdiv(sx(w[15:0]), d))};
   endfunction

   function automatic logic [15:0] ref_neg(input logic [15:0] v);
      if (sx(v) == -32768) return 16'h7FFF;
      return 16'(-sx(v));
   endfunction

   // Ready source: constant 1 or a 50% coin flip per cycle.
   initial forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
   end

   // IFFT stand-in: checks NFFT consecutive ce samples, then after LAT cycles streams td[].
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (reset || !ifft_ce) begin
            cnt = 0;
         end else begin
            if (coef_q.size() == 0) fail_now("ifft_in_extra");
            else check("ifft_in", 64'(ifft_in), 64'(coef_q.pop_front()));
            cnt++;
            if (cnt == NFFT) begin
               repeat (LAT) @(posedge clk);
               #1;
               for (int n = 0; n < NFFT; n++) begin
                  ifft_sync = (n == 0);
                  ifft_out  = td[n];
                  @(posedge clk);
                  #1;
               end
               ifft_sync = 1'b0;
               ifft_out  = $urandom;
               cnt = 0;
            end
         end
      end
   end

   // Output monitor: pops the scoreboard on every accepted sample, checks stall stability.
   initial begin
      bit          prev_stall;
      logic [31:0] prev_iq;
      logic        prev_last;
      logic [32:0] e;
      prev_stall = 1'b0;
      prev_iq    = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && out_valid) begin
               check("stall_iq", 64'(out_iq), 64'(prev_iq));
               check("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  fail_now("out_unexpected");
               end else begin
                  e = exp_q.pop_front();
                  check("out_iq", 64'(out_iq), 64'(e[31:0]));
                  check("out_last", 64'(out_last), 64'(e[32]));
               end
               acc_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_iq    = out_iq;
            prev_last  = out_last;
         end
      end
   end

   // Build ROM/codes/time data and push expected coefficients and output samples.
   task automatic setup_burst(input int n_req, input logic [3:0] sg, input int rom_mode,
                              input int code_mode, input int td_mode, output int neff,
                              output logic [127:0] codes);
      logic [1:0]  c;
      logic [31:0] v;
      int          k;
      for (int i = 0; i < NFFT; i++) begin
         rom_mem[i] = (rom_mode == 0) ? 32'h4000_C000 : (rom_mode == 1) ? 32'h0800_F800 : $urandom;
         td[i]      = (td_mode == 1) ? {16'(i), 16'(i)} : $urandom;
         c          = (code_mode == 0) ? 2'b10 : (code_mode == 1) ? 2'(i % 4) : 2'($urandom);
         codes[2*i +: 2] = c;
      end
      if (td_mode == 1) td[50] = 32'h8000_8000;
      for (int i = 0; i < NFFT; i++) coef_q.push_back(ref_scale(rom_mem[i], codes[2*i +: 2]));
      neff = (n_req == 0) ? 1 : (n_req > 4) ? 4 : n_req;
      for (int s = 0; s < neff; s++) begin
         for (int p = 0; p < int'(SLEN); p++) begin
            k = (p < int'(CP_LEN)) ? int'(NFFT - CP_LEN) + p : p - int'(CP_LEN);
            v = td[k];
            if (sg[s]) v = {ref_neg(v[31:16]), ref_neg(v[15:0])};
            exp_q.push_back({(s == neff - 1) && (p == int'(SLEN) - 1), v});
         end
      end
   endtask

   task automatic pulse_start(input int n_req, input logic [3:0] sg, input logic [127:0] codes);
      @(posedge clk);
      #1;
      acc_cnt   = 0;
      nsym      = 3'(n_req);
      sym_sign  = sg;
      obf_coeff = codes;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      nsym      = 3'($urandom);
      sym_sign  = 4'($urandom);
      obf_coeff = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic run_burst(input int n_req, input logic [3:0] sg, input int rom_mode,
                            input int code_mode, input int td_mode, input bit rr, input bit poke);
      int           neff;
      logic [127:0] codes;
      bit           done;
      bit           poked;
      done  = 1'b0;
      poked = 1'b0;
      setup_burst(n_req, sg, rom_mode, code_mode, td_mode, neff, codes);
      rdy_rand = rr;
      pulse_start(n_req, sg, codes);
      for (int c = 0; c < 5000 && !done; c++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
         else if (poke && !poked && acc_cnt >= 10) begin
            @(posedge clk);
            #1;
            nsym  = 3'd1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            poked = 1'b1;
         end
      end
      check("burst_done", 64'(done), 64'(1));
      check("burst_len", 64'(acc_cnt), 64'(neff * int'(SLEN)));
      check("sb_empty", 64'(exp_q.size()), 64'(0));
      check("coef_empty", 64'(coef_q.size()), 64'(0));
      check("idle_valid", 64'(out_valid), 64'(0));
      exp_q.delete();
      coef_q.delete();
      rdy_rand = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   // Abort a burst with reset once 37 samples have been accepted.
   task automatic reset_mid_burst();
      int           neff;
      logic [127:0] codes;
      bit           hit;
      hit = 1'b0;
      setup_burst(2, 4'b0110, 2, 2, 0, neff, codes);
      rdy_rand = 1'b1;
      pulse_start(2, 4'b0110, codes);
      for (int c = 0; c < 5000 && !hit; c++) begin
         @(negedge clk);
         if (acc_cnt >= 37) hit = 1'b1;
      end
      check("reached_37", 64'(hit), 64'(1));
      check("busy_before_reset", 64'(busy), 64'(1));
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_valid", 64'(out_valid), 64'(0));
      check("rst_mid_busy", 64'(busy), 64'(0));
      check("rst_mid_last", 64'(out_last), 64'(0));
      check("rst_mid_ce", 64'(ifft_ce), 64'(0));
      exp_q.delete();
      coef_q.delete();
      rdy_rand = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < NFFT; i++) begin
         rom_mem[i] = '0;
         td[i]      = '0;
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
      check("rst_out_iq", 64'(out_iq), 64'(0));
      check("rst_ifft_ce", 64'(ifft_ce), 64'(0));
      check("rst_ifft_in", 64'(ifft_in), 64'(0));
      check("rst_rom_addr", 64'(rom_addr), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));

      run_burst(1, 4'b0000, 0, 0, 0, 1'b0, 1'b0);
      run_burst(2, 4'($urandom), 1, 1, 0, 1'b1, 1'b0);
      run_burst(4, 4'b1010, 2, 2, 1, 1'b0, 1'b0);
      run_burst(3, 4'($urandom), 2, 2, 0, 1'b1, 1'b1);
      run_burst(0, 4'($urandom), 2, 2, 0, 1'b1, 1'b0);
      run_burst(7, 4'($urandom), 2, 2, 0, 1'b1, 1'b0);
      reset_mid_burst();
      run_burst(2, 4'($urandom), 2, 2, 0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
